uart_core_cfg: RTL and testbench

Parametrised full-duplex UART core and successor to the fixed 8N1 uart block. It has compile-time data width (5–9 bits), parity mode (none/even/odd), stop-bit count and oversampling factor. It adds a valid/ready TX handshake, majority-vote RX sampling, false-start rejection, and parity and framing error reporting. It sits between the system bus/register block and the pads; rx_in comes directly from the pin and is asynchronous.

---
 rtl/uart_core_cfg.sv | 293 +++++++++++++++++++++++++++++
 tb/tb_uart_core_cfg.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_core_cfg.sv
// ---------------------------------------------------------------------------
// uart_core_cfg
// Parametrised full-duplex UART core with configurable data width (5..9),
// parity (0 none / 1 even / 2 odd), TX stop bits (1 or 2) and oversampling.
//
// Ports
//   clk, rst          : system clock (rising edge), asynchronous active-high reset
//   tx_valid/tx_ready : TX handshake; word accepted when both are high
//   tx_data           : TX word, LSB sent first
//   tx_busy           : a TX frame is on the line
//   tx_out            : serial output, idle high
//   rx_in             : serial input straight from the pin (asynchronous)
//   rx_data           : last received word
//   rx_valid          : one-cycle pulse, rx_data and error flags just updated
//   rx_parity_err     : parity mismatch on last frame
//   rx_frame_err      : stop bit sampled low on last frame
//   rx_busy           : RX frame in progress
// ---------------------------------------------------------------------------
module uart_core_cfg #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx_busy,
    output logic                 tx_out,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_busy
);
    localparam int TICK_RATE = BAUD_RATE * OVERSAMPLE;
    localparam int DIV_RAW   = (CLK_FREQ + TICK_RATE / 2) / TICK_RATE;
    localparam int DIV       = (DIV_RAW < 1) ? 1 : DIV_RAW;
    localparam int BIT_CLKS  = DIV * OVERSAMPLE;
    localparam int CNT_W     = $clog2(BIT_CLKS);
    localparam int DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int SUB_W     = $clog2(OVERSAMPLE);

    // ------------------------------------------------------------------ TX
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

    tx_state_t            r_tx_state, w_tx_state_next;
    logic [CNT_W-1:0]     r_tx_cnt, w_tx_cnt_next;
    logic [3:0]           r_tx_bit, w_tx_bit_next;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_next;
    logic                 r_tx_par, w_tx_par_next;
    logic                 r_tx_out, w_tx_out_next;
    logic                 r_tx_busy, w_tx_busy_next;
    logic                 w_tx_bit_end;

    assign w_tx_bit_end = (r_tx_cnt == CNT_W'(BIT_CLKS - 1));

    always_comb begin
        w_tx_state_next = r_tx_state;
        w_tx_cnt_next   = r_tx_cnt + CNT_W'(1);
        w_tx_bit_next   = r_tx_bit;
        w_tx_shift_next = r_tx_shift;
        w_tx_par_next   = r_tx_par;
        w_tx_out_next   = r_tx_out;
        w_tx_busy_next  = r_tx_busy;
        case (r_tx_state)
            TX_IDLE: begin
                w_tx_cnt_next  = '0;
                w_tx_out_next  = 1'b1;
                w_tx_busy_next = 1'b0;
                if (tx_valid) begin
                    w_tx_state_next = TX_START;
                    w_tx_shift_next = tx_data;
                    w_tx_par_next   = (PARITY == 2) ? ~(^tx_data) : (^tx_data);
                    w_tx_bit_next   = '0;
                    w_tx_out_next   = 1'b0;
                    w_tx_busy_next  = 1'b1;
                end
            end
            TX_START: begin
                if (w_tx_bit_end) begin
                    w_tx_state_next = TX_DATA;
                    w_tx_cnt_next   = '0;
                    w_tx_out_next   = r_tx_shift[0];
                end
            end
            TX_DATA: begin
                if (w_tx_bit_end) begin
                    w_tx_cnt_next = '0;
                    if (r_tx_bit == 4'(DATA_BITS - 1)) begin
                        w_tx_bit_next = '0;
                        if (PARITY != 0) begin
                            w_tx_state_next = TX_PARITY;
                            w_tx_out_next   = r_tx_par;
                        end else begin
                            w_tx_state_next = TX_STOP;
                            w_tx_out_next   = 1'b1;
                        end
                    end else begin
                        w_tx_bit_next   = r_tx_bit + 4'd1;
                        w_tx_shift_next = r_tx_shift >> 1;
                        w_tx_out_next   = r_tx_shift[1];
                    end
                end
            end
            TX_PARITY: begin
                if (w_tx_bit_end) begin
                    w_tx_state_next = TX_STOP;
                    w_tx_cnt_next   = '0;
                    w_tx_bit_next   = '0;
                    w_tx_out_next   = 1'b1;
                end
            end
            TX_STOP: begin
                // The final stop clock is spent in IDLE with tx_ready high, so a
                // held tx_valid starts the next frame exactly one bit time after
                // the last stop bit began, with no extra idle cycle.
                if (r_tx_bit == 4'(STOP_BITS - 1) && r_tx_cnt == CNT_W'(BIT_CLKS - 2)) begin
                    w_tx_state_next = TX_IDLE;
                    w_tx_cnt_next   = '0;
                end else if (w_tx_bit_end) begin
                    w_tx_cnt_next = '0;
                    w_tx_bit_next = r_tx_bit + 4'd1;
                end
            end
            default: w_tx_state_next = TX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_tx_par   <= 1'b0;
            r_tx_out   <= 1'b1;
            r_tx_busy  <= 1'b0;
        end else begin
            r_tx_state <= w_tx_state_next;
            r_tx_cnt   <= w_tx_cnt_next;
            r_tx_bit   <= w_tx_bit_next;
            r_tx_shift <= w_tx_shift_next;
            r_tx_par   <= w_tx_par_next;
            r_tx_out   <= w_tx_out_next;
            r_tx_busy  <= w_tx_busy_next;
        end
    end

    assign tx_ready = (r_tx_state == TX_IDLE);
    assign tx_busy  = r_tx_busy;
    assign tx_out   = r_tx_out;

    // ------------------------------------------------------------------ RX
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP,
                              RX_WAIT_HIGH} rx_state_t;

    rx_state_t            r_rx_state, w_rx_state_next;
    logic                 r_sync1, r_sync2, r_rx_s;
    logic [DIV_W-1:0]     r_rx_div, w_rx_div_next;
    logic [SUB_W-1:0]     r_rx_sub, w_rx_sub_next;
    logic [3:0]           r_rx_bit, w_rx_bit_next;
    logic [DATA_BITS-1:0] r_rx_shift, w_rx_shift_next;
    logic                 r_rx_v0, r_rx_v1, r_rx_par, w_rx_par_next;
    logic [DATA_BITS-1:0] r_rx_data, w_rx_data_next;
    logic                 r_rx_valid, w_rx_valid_next;
    logic                 r_rx_perr, w_rx_perr_next;
    logic                 r_rx_ferr, w_rx_ferr_next;
    logic                 w_rx_div_wrap, w_rx_sub_wrap, w_rx_at_v0, w_rx_at_v1;
    logic                 w_rx_decide, w_rx_maj, w_rx_par_exp;

    assign w_rx_div_wrap = (r_rx_div == DIV_W'(DIV - 1));
    assign w_rx_sub_wrap = (r_rx_sub == SUB_W'(OVERSAMPLE - 1));
    // Samples are taken on the first clock of sub-ticks OS/2-1, OS/2, OS/2+1.
    assign w_rx_at_v0    = (r_rx_div == '0) && (r_rx_sub == SUB_W'(OVERSAMPLE / 2 - 1));
    assign w_rx_at_v1    = (r_rx_div == '0) && (r_rx_sub == SUB_W'(OVERSAMPLE / 2));
    assign w_rx_decide   = (r_rx_div == '0) && (r_rx_sub == SUB_W'(OVERSAMPLE / 2 + 1));
    assign w_rx_maj      = (r_rx_v0 & r_rx_v1) | (r_rx_v0 & r_rx_s) | (r_rx_v1 & r_rx_s);
    assign w_rx_par_exp  = (PARITY == 2) ? ~(^r_rx_shift) : (^r_rx_shift);

    always_comb begin
        w_rx_state_next = r_rx_state;
        w_rx_div_next   = w_rx_div_wrap ? '0 : r_rx_div + DIV_W'(1);
        w_rx_sub_next   = r_rx_sub;
        if (w_rx_div_wrap) w_rx_sub_next = w_rx_sub_wrap ? '0 : r_rx_sub + SUB_W'(1);
        w_rx_bit_next   = r_rx_bit;
        w_rx_shift_next = r_rx_shift;
        w_rx_par_next   = r_rx_par;
        w_rx_data_next  = r_rx_data;
        w_rx_valid_next = 1'b0;
        w_rx_perr_next  = r_rx_perr;
        w_rx_ferr_next  = r_rx_ferr;
        case (r_rx_state)
            RX_IDLE: begin
                w_rx_div_next = '0;
                w_rx_sub_next = '0;
                if (r_rx_s && !r_sync2) w_rx_state_next = RX_START;
            end
            RX_START: begin
                if (w_rx_decide) begin
                    w_rx_bit_next   = '0;
                    w_rx_state_next = w_rx_maj ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_decide) begin
                    w_rx_shift_next = {w_rx_maj, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_bit == 4'(DATA_BITS - 1)) begin
                        w_rx_bit_next   = '0;
                        w_rx_state_next = (PARITY != 0) ? RX_PARITY : RX_STOP;
                    end else begin
                        w_rx_bit_next = r_rx_bit + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (w_rx_decide) begin
                    w_rx_par_next   = w_rx_maj;
                    w_rx_state_next = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_decide) begin
                    w_rx_valid_next = 1'b1;
                    w_rx_data_next  = r_rx_shift;
                    w_rx_perr_next  = (PARITY != 0) ? (r_rx_par != w_rx_par_exp) : 1'b0;
                    w_rx_ferr_next  = ~w_rx_maj;
                    w_rx_state_next = w_rx_maj ? RX_IDLE : RX_WAIT_HIGH;
                    w_rx_div_next   = '0;
                    w_rx_sub_next   = '0;
                end
            end
            RX_WAIT_HIGH: begin
                // Counter measures how long the line has been continuously high.
                if (!r_rx_s) begin
                    w_rx_div_next = '0;
                    w_rx_sub_next = '0;
                end else if (w_rx_div_wrap && w_rx_sub_wrap) begin
                    w_rx_state_next = RX_IDLE;
                end
            end
            default: w_rx_state_next = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_rx_s     <= 1'b1;
            r_rx_state <= RX_IDLE;
            r_rx_div   <= '0;
            r_rx_sub   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_v0    <= 1'b1;
            r_rx_v1    <= 1'b1;
            r_rx_par   <= 1'b0;
            r_rx_data  <= '0;
            r_rx_valid <= 1'b0;
            r_rx_perr  <= 1'b0;
            r_rx_ferr  <= 1'b0;
        end else begin
            r_sync1    <= rx_in;
            r_sync2    <= r_sync1;
            r_rx_s     <= r_sync2;
            r_rx_state <= w_rx_state_next;
            r_rx_div   <= w_rx_div_next;
            r_rx_sub   <= w_rx_sub_next;
            r_rx_bit   <= w_rx_bit_next;
            r_rx_shift <= w_rx_shift_next;
            if (w_rx_at_v0) r_rx_v0 <= r_rx_s;
            if (w_rx_at_v1) r_rx_v1 <= r_rx_s;
            r_rx_par   <= w_rx_par_next;
            r_rx_data  <= w_rx_data_next;
            r_rx_valid <= w_rx_valid_next;
            r_rx_perr  <= w_rx_perr_next;
            r_rx_ferr  <= w_rx_ferr_next;
        end
    end

    assign rx_data       = r_rx_data;
    assign rx_valid      = r_rx_valid;
    assign rx_parity_err = r_rx_perr;
    assign rx_frame_err  = r_rx_ferr;
    assign rx_busy       = (r_rx_state != RX_IDLE);

endmodule

// File: tb/tb_uart_core_cfg.sv
// ---------------------------------------------------------------------------
// tb_uart_core_cfg
// Directed bench for uart_core_cfg. Three instances share clk/rst:
//   A: 8N1, B: 8 data odd parity 1 stop, C: 7 data even parity 2 stop.
// The clock rate is chosen so DIV = 4 and one bit = 64 clocks, keeping runs
// short. Each RX input is either looped back from its own tx_out or driven
// from a bench-generated pin waveform.
// ---------------------------------------------------------------------------
module tb_uart_core_cfg;
    localparam int CLK_HZ = 7_372_800;
    localparam int BAUD   = 115200;
    localparam int OS     = 16;
    localparam int BIT    = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tb_pin = 1'b1;

    logic       a_sel = 1'b0, b_sel = 1'b0, c_sel = 1'b0;
    logic       a_tx_valid = 1'b0, b_tx_valid = 1'b0, c_tx_valid = 1'b0;
    logic [7:0] a_tx_data = '0, b_tx_data = '0;
    logic [6:0] c_tx_data = '0;

    logic       a_tx_ready, a_tx_busy, a_tx_out, a_rx_in, a_rx_valid, a_rx_perr, a_rx_ferr, a_rx_busy;
    logic       b_tx_ready, b_tx_busy, b_tx_out, b_rx_in, b_rx_valid, b_rx_perr, b_rx_ferr, b_rx_busy;
    logic       c_tx_ready, c_tx_busy, c_tx_out, c_rx_in, c_rx_valid, c_rx_perr, c_rx_ferr, c_rx_busy;
    logic [7:0] a_rx_data, b_rx_data;
    logic [6:0] c_rx_data;

    assign a_rx_in = a_sel ? tb_pin : a_tx_out;
    assign b_rx_in = b_sel ? tb_pin : b_tx_out;
    assign c_rx_in = c_sel ? tb_pin : c_tx_out;

    always #5 clk = ~clk;

    uart_core_cfg #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(0),
                    .STOP_BITS(1), .OVERSAMPLE(OS)) u_a (
        .clk(clk), .rst(rst), .tx_valid(a_tx_valid), .tx_data(a_tx_data),
        .tx_ready(a_tx_ready), .tx_busy(a_tx_busy), .tx_out(a_tx_out), .rx_in(a_rx_in),
        .rx_data(a_rx_data), .rx_valid(a_rx_valid), .rx_parity_err(a_rx_perr),
        .rx_frame_err(a_rx_ferr), .rx_busy(a_rx_busy));

    uart_core_cfg #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(8), .PARITY(2),
                    .STOP_BITS(1), .OVERSAMPLE(OS)) u_b (
        .clk(clk), .rst(rst), .tx_valid(b_tx_valid), .tx_data(b_tx_data),
        .tx_ready(b_tx_ready), .tx_busy(b_tx_busy), .tx_out(b_tx_out), .rx_in(b_rx_in),
        .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_parity_err(b_rx_perr),
        .rx_frame_err(b_rx_ferr), .rx_busy(b_rx_busy));

    uart_core_cfg #(.CLK_FREQ(CLK_HZ), .BAUD_RATE(BAUD), .DATA_BITS(7), .PARITY(1),
                    .STOP_BITS(2), .OVERSAMPLE(OS)) u_c (
        .clk(clk), .rst(rst), .tx_valid(c_tx_valid), .tx_data(c_tx_data),
        .tx_ready(c_tx_ready), .tx_busy(c_tx_busy), .tx_out(c_tx_out), .rx_in(c_rx_in),
        .rx_data(c_rx_data), .rx_valid(c_rx_valid), .rx_parity_err(c_rx_perr),
        .rx_frame_err(c_rx_ferr), .rx_busy(c_rx_busy));

    // rx_valid logs: entry = {parity_err, frame_err, data zero-extended to 9 bits}
    int          a_cnt = 0, b_cnt = 0, c_cnt = 0;
    logic [10:0] a_log [32];
    logic [10:0] b_log [32];
    logic [10:0] c_log [32];

    always @(negedge clk) if (a_rx_valid) begin
        a_log[a_cnt[4:0]] <= {a_rx_perr, a_rx_ferr, 1'b0, a_rx_data};
        a_cnt <= a_cnt + 1;
    end
    always @(negedge clk) if (b_rx_valid) begin
        b_log[b_cnt[4:0]] <= {b_rx_perr, b_rx_ferr, 1'b0, b_rx_data};
        b_cnt <= b_cnt + 1;
    end
    always @(negedge clk) if (c_rx_valid) begin
        c_log[c_cnt[4:0]] <= {c_rx_perr, c_rx_ferr, 2'b00, c_rx_data};
        c_cnt <= c_cnt + 1;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int get_cnt(input int inst);
        case (inst)
            0:       return a_cnt;
            1:       return b_cnt;
            default: return c_cnt;
        endcase
    endfunction

    function automatic logic [10:0] get_log(input int inst, input int idx);
        case (inst)
            0:       return a_log[idx[4:0]];
            1:       return b_log[idx[4:0]];
            default: return c_log[idx[4:0]];
        endcase
    endfunction

    task automatic wait_count(input int inst, input int target);
        int n;
        n = 0;
        while (get_cnt(inst) < target && n < 4000) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
    endtask

    // Check the rx_valid log entry idx of an instance.
    task automatic chk_rx(input string tag, input int inst, input int idx,
                          input logic [8:0] data, input logic perr, input logic ferr);
        logic [10:0] e;
        e = get_log(inst, idx);
        chk({tag, "_data"}, 32'(e[8:0]), 32'(data));
        chk({tag, "_perr"}, 32'(e[10]), 32'(perr));
        chk({tag, "_ferr"}, 32'(e[9]), 32'(ferr));
    endtask

    // Drive the pin from a packed bit list (bit 0 first), one bit per BIT clocks.
    // Frame clock offsets g_at-1 and g_at are inverted to model a short glitch.
    task automatic drive_bits(input logic [31:0] bits, input int nbits, input int g_at);
        for (int o = 0; o < nbits * BIT; o++) begin
            tb_pin = bits[o / BIT] ^ ((o == g_at) || (o == g_at - 1));
            @(negedge clk);
        end
        tb_pin = 1'b1;
    endtask

    task automatic idle_bits(input int n);
        tb_pin = 1'b1;
        repeat (n * BIT) @(negedge clk);
    endtask

    // Loopback frame on instance A: handshake, busy length, received word.
    task automatic a_frame(input string tag, input logic [7:0] d);
        int n;
        int base;
        base = a_cnt;
        @(negedge clk);
        a_tx_data  = d;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        a_tx_data  = ~d;
        chk({tag, "_txout_start"}, 32'(a_tx_out), 32'd0);
        chk({tag, "_ready_low"}, 32'(a_tx_ready), 32'd0);
        n = 0;
        while (a_tx_busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk({tag, "_busy_clocks"}, 32'(n), 32'd640);
        wait_count(0, base + 1);
        chk({tag, "_count"}, 32'(a_cnt), 32'(base + 1));
        chk_rx(tag, 0, base, {1'b0, d}, 1'b0, 1'b0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        logic par_seen;

        repeat (3) @(negedge clk);
        // Reset state, sampled while rst is held
        chk("rst_tx_out", 32'(a_tx_out), 32'd1);
        chk("rst_tx_ready", 32'(a_tx_ready), 32'd1);
        chk("rst_tx_busy", 32'(a_tx_busy), 32'd0);
        chk("rst_rx_data", 32'(a_rx_data), 32'd0);
        chk("rst_rx_valid", 32'(a_rx_valid), 32'd0);
        chk("rst_rx_perr", 32'(a_rx_perr), 32'd0);
        chk("rst_rx_ferr", 32'(a_rx_ferr), 32'd0);
        chk("rst_rx_busy", 32'(a_rx_busy), 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 loopback
        a_frame("a55", 8'h55);
        a_frame("aAA", 8'hAA);

        // 8O1 loopback: 0x01 has one set bit, so odd parity bit is 0
        base = b_cnt;
        @(negedge clk);
        b_tx_data  = 8'h01;
        b_tx_valid = 1'b1;
        @(negedge clk);
        b_tx_valid = 1'b0;
        repeat (9 * BIT + 32) @(negedge clk);
        chk("b_parity_bit", 32'(b_tx_out), 32'd0);
        wait_count(1, base + 1);
        chk("b01_count", 32'(b_cnt), 32'(base + 1));
        chk_rx("b01", 1, base, 9'h001, 1'b0, 1'b0);

        // 8O1 bench frame with parity bit inverted (1 instead of 0)
        repeat (BIT) @(negedge clk);
        b_sel = 1'b1;
        base  = b_cnt;
        drive_bits({21'd0, 1'b1, 1'b1, 8'h01, 1'b0}, 11, -10);
        idle_bits(1);
        chk("bperr_count", 32'(b_cnt), 32'(base + 1));
        chk_rx("bperr", 1, base, 9'h001, 1'b1, 1'b0);
        b_sel = 1'b0;

        // 7E2 back-to-back with tx_valid held: 0x3A then 0x45
        base = c_cnt;
        @(negedge clk);
        c_tx_data  = 7'h3A;
        c_tx_valid = 1'b1;
        @(negedge clk);
        chk("c_first_start", 32'(c_tx_out), 32'd0);
        c_tx_data = 7'h45;
        n = 1;
        par_seen = 1'b1;
        while (!c_tx_ready && n < 2000) begin
            if (n - 1 == 8 * BIT + 32) par_seen = c_tx_out;
            @(negedge clk);
            n++;
        end
        chk("c_start_spacing", 32'(n), 32'd704);
        chk("c_parity_3A", 32'(par_seen), 32'd0);
        chk("c_busy_at_handover", 32'(c_tx_busy), 32'd1);
        @(negedge clk);
        c_tx_valid = 1'b0;
        chk("c_second_start", 32'(c_tx_out), 32'd0);
        chk("c_second_ready", 32'(c_tx_ready), 32'd0);
        wait_count(2, base + 2);
        chk("c_count", 32'(c_cnt), 32'(base + 2));
        chk_rx("c3A", 2, base, 9'h03A, 1'b0, 1'b0);
        chk_rx("c45", 2, base + 1, 9'h045, 1'b0, 1'b0);

        // A: stop bit low, then a long break, then a clean word
        repeat (2 * BIT) @(negedge clk);
        a_sel = 1'b1;
        base  = a_cnt;
        drive_bits({22'd0, 1'b0, 8'hC3, 1'b0}, 10, -10);
        idle_bits(2);
        chk("aC3_count", 32'(a_cnt), 32'(base + 1));
        chk_rx("aC3", 0, base, 9'h0C3, 1'b0, 1'b1);
        drive_bits(32'd0, 30, -10);
        idle_bits(2);
        chk("break_count", 32'(a_cnt), 32'(base + 2));
        chk_rx("break", 0, base + 1, 9'h000, 1'b0, 1'b1);
        drive_bits({22'd0, 1'b1, 8'h5A, 1'b0}, 10, -10);
        idle_bits(1);
        chk("a5A_count", 32'(a_cnt), 32'(base + 3));
        chk_rx("a5A", 0, base + 2, 9'h05A, 1'b0, 1'b0);

        // A: short low pulse on idle line is a false start
        base   = a_cnt;
        tb_pin = 1'b0;
        repeat (4 * 4) @(negedge clk);
        tb_pin = 1'b1;
        chk("false_start_busy", 32'(a_rx_busy), 32'd1);
        idle_bits(2);
        chk("false_start_count", 32'(a_cnt), 32'(base));
        chk("false_start_idle", 32'(a_rx_busy), 32'd0);

        // A: glitch on the centre sample of data bit 3 (frame bit 4)
        drive_bits({22'd0, 1'b1, 8'hA5, 1'b0}, 10, 4 * BIT + 32);
        idle_bits(1);
        chk("glitch_count", 32'(a_cnt), 32'(base + 1));
        chk_rx("glitch", 0, base, 9'h0A5, 1'b0, 1'b0);
        a_sel = 1'b0;

        // Reset in the middle of a loopback frame
        repeat (BIT) @(negedge clk);
        base = a_cnt;
        a_tx_data  = 8'h33;
        a_tx_valid = 1'b1;
        @(negedge clk);
        a_tx_valid = 1'b0;
        repeat (300) @(negedge clk);
        chk("mid_tx_busy", 32'(a_tx_busy), 32'd1);
        chk("mid_rx_busy", 32'(a_rx_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_async_tx_out", 32'(a_tx_out), 32'd1);
        chk("rst_async_tx_busy", 32'(a_tx_busy), 32'd0);
        chk("rst_async_rx_busy", 32'(a_rx_busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(a_tx_ready), 32'd1);
        repeat (12 * BIT) @(negedge clk);
        chk("post_rst_no_valid", 32'(a_cnt), 32'(base));
        a_frame("a7E", 8'h7E);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
